// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
// Contents: FSM state encoding, requester port indices, default memory depth.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int DEPTH_DEFAULT = 32;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rtl/dm_arbiter_rr_arb2.sv - combinational two-way round-robin picker
// Ports:
//   req0, req1  : requests from port 0 / port 1
//   last_grant  : port index granted most recently
//   gnt_valid   : at least one request present
//   gnt_idx     : index of the port to grant
import dm_pkg::*;

module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = P0;
    if (req0 && req1) begin
      // On a tie the port that did not win last time goes next.
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = P1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter sharing one data memory between two requesters
// Ports:
//   clk, reset              : clock (rising edge), async active-high reset
//   req*/we*/addr*/wd*      : requester 0/1 request, write flag, word address, write data
//   ack*/rd*/err*           : one-cycle completion pulse, registered read data, out-of-range flag
//   dm_addr/dm_wd/dm_we     : memory address, write data, write enable
//   dm_rd                   : memory combinational read data
//   busy                    : high whenever an access is in progress (state != IDLE)
import dm_pkg::*;

module dm_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic          ack0,
  output logic [DW-1:0] rd0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic          ack1,
  output logic [DW-1:0] rd1,
  output logic          err1,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rd,
  output logic          busy
);

  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH);

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          owner_q;
  logic          lat_we_q;
  logic          oor_q;
  logic [AW-1:0] lat_addr_q;
  logic [DW-1:0] lat_wd_q;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    sel_we   = we0;
    sel_addr = addr0;
    sel_wd   = wd0;
    if (gnt_idx == P1) begin
      sel_we   = we1;
      sel_addr = addr1;
      sel_wd   = wd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The memory sees the latched request; the enable depends only on
  // registered state, so an async reset removes it immediately.
  always_comb begin
    dm_addr = lat_addr_q;
    dm_wd   = lat_wd_q;
    dm_we   = (state_q == ACCESS) && lat_we_q && !oor_q;
    busy    = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= P1;
      owner_q      <= P0;
      lat_we_q     <= 1'b0;
      oor_q        <= 1'b0;
      lat_addr_q   <= '0;
      lat_wd_q     <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rd0          <= '0;
      rd1          <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q    <= gnt_idx;
            lat_we_q   <= sel_we;
            lat_addr_q <= sel_addr;
            lat_wd_q   <= sel_wd;
            oor_q      <= (sel_addr >= ADDR_LIMIT);
          end
        end
        ACCESS: begin
          last_grant_q <= owner_q;
          if (owner_q == P0) begin
            ack0 <= 1'b1;
            err0 <= oor_q;
            if (!lat_we_q) rd0 <= oor_q ? '0 : dm_rd;
          end else begin
            ack1 <= 1'b1;
            err1 <= oor_q;
            if (!lat_we_q) rd1 <= oor_q ? '0 : dm_rd;
          end
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err0 <= 1'b0;
          err1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter with a 32-word memory model
module tb_dm_arbiter;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1, dm_addr;
  logic [31:0] wd0, wd1, rd0, rd1, dm_wd, dm_rd;
  logic        ack0, ack1, err0, err1, dm_we, busy;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic [31:0] model_rd [0:1];

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  int vectors, miscompares;
  int cyc, ack_cyc, issue_cyc, we_cnt;
  logic [15:0] we_addr;
  logic hold_req;

  assign dm_rd = mem[dm_addr[4:0]];

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0),
    .ack0(ack0), .rd0(rd0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1),
    .ack1(ack1), .rd1(rd1), .err1(err1),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we),
    .dm_rd(dm_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input logic p, input logic we, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    logic oor;
    oor = (a >= 16'd32);
    if (!oor && we) ref_mem[a[4:0]] = d;
    if (!we) model_rd[p] = oor ? 32'h0 : ref_mem[a[4:0]];
    e.port = p;
    e.err  = oor;
    e.rd   = model_rd[p];
    sb.push_back(e);
  endtask

  task automatic check_ack();
    exp_t e;
    logic p;
    p = ack1;
    ack_cyc = cyc;
    if (sb.size() == 0) begin
      chk("unexpected_ack", {31'b0, p}, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("ack_port", {31'b0, p}, {31'b0, e.port});
      chk("ack_err", {31'b0, (p ? err1 : err0)}, {31'b0, e.err});
      chk("ack_rd", (p ? rd1 : rd0), e.rd);
    end
    if (!hold_req) begin
      if (p) req1 = 1'b0;
      else   req0 = 1'b0;
    end
  endtask

  // One clock: memory write at the edge, then sample #1 later.
  task automatic step();
    logic        we_s;
    logic [15:0] a_s;
    logic [31:0] d_s;
    we_s = dm_we;
    a_s  = dm_addr;
    d_s  = dm_wd;
    @(posedge clk);
    if (we_s) begin
      mem[a_s[4:0]] <= d_s;
      we_cnt++;
      we_addr = a_s;
    end
    #1;
    cyc++;
    chk("ack_overlap", {31'b0, ack0 & ack1}, 32'h0);
    if (ack0 || ack1) check_ack();
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'b0, n >= max}, 32'h0);
  endtask

  task automatic issue(input logic p, input logic we, input logic [15:0] a, input logic [31:0] d);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wd1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wd0 = d; end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; ack_cyc = 0; issue_cyc = 0;
    we_cnt = 0; we_addr = '0; hold_req = 1'b0;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wd0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wd1 = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;

    do_reset();
    chk("rst_ack0", {31'b0, ack0}, 0);
    chk("rst_ack1", {31'b0, ack1}, 0);
    chk("rst_err0", {31'b0, err0}, 0);
    chk("rst_err1", {31'b0, err1}, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_dm_we", {31'b0, dm_we}, 0);
    chk("rst_dm_addr", {16'b0, dm_addr}, 0);
    chk("rst_dm_wd", dm_wd, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    // Port 0 write then read of word 5
    we_cnt = 0;
    issue(0, 1, 16'd5, 32'hDEADBEEF);
    model_access(0, 1, 16'd5, 32'hDEADBEEF);
    issue_cyc = cyc;
    run_idle(20);
    chk("wr_latency", ack_cyc - issue_cyc, 2);
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_we_addr", {16'b0, we_addr}, 5);
    issue(0, 0, 16'd5, 32'h0);
    model_access(0, 0, 16'd5, 32'h0);
    issue_cyc = cyc;
    run_idle(20);
    chk("rd_latency", ack_cyc - issue_cyc, 2);

    // Simultaneous requests from reset: port 0 wins the first tie
    do_reset();
    issue(0, 0, 16'd3, 32'h0);
    issue(1, 1, 16'd3, 32'h12345678);
    model_access(0, 0, 16'd3, 32'h0);
    model_access(1, 1, 16'd3, 32'h12345678);
    run_idle(30);
    issue(0, 0, 16'd3, 32'h0);
    model_access(0, 0, 16'd3, 32'h0);
    run_idle(20);

    // Continuous contention for 12 cycles
    do_reset();
    hold_req = 1'b1;
    issue(0, 0, 16'd2, 32'h0);
    issue(1, 1, 16'd2, 32'hCAFEF00D);
    model_access(0, 0, 16'd2, 32'h0);
    model_access(1, 1, 16'd2, 32'hCAFEF00D);
    model_access(0, 0, 16'd2, 32'h0);
    model_access(1, 1, 16'd2, 32'hCAFEF00D);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("cont_busy", {31'b0, busy}, {31'b0, (k % 3) != 0});
    end
    req0 = 1'b0; req1 = 1'b0;
    hold_req = 1'b0;
    chk("cont_all_acked", sb.size(), 0);
    run_idle(10);

    // Out-of-range write and read on port 1
    issue(1, 0, 16'd2, 32'h0);
    model_access(1, 0, 16'd2, 32'h0);
    run_idle(20);
    we_cnt = 0;
    issue(1, 1, 16'd32, 32'hFFFFFFFF);
    model_access(1, 1, 16'd32, 32'hFFFFFFFF);
    run_idle(20);
    chk("oor_we_cycles", we_cnt, 0);
    chk("oor_word0", mem[0], ref_mem[0]);
    issue(1, 0, 16'd40, 32'h0);
    model_access(1, 0, 16'd40, 32'h0);
    run_idle(20);

    // Reset during the ACCESS cycle of a write to word 7
    we_cnt = 0;
    issue(0, 1, 16'd7, 32'h77777777);
    step();
    chk("abort_we_before", {31'b0, dm_we}, 1);
    reset = 1'b1;
    #1;
    chk("abort_we_async", {31'b0, dm_we}, 0);
    chk("abort_busy_async", {31'b0, busy}, 0);
    req0 = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    repeat (3) step();
    chk("abort_we_cycles", we_cnt, 0);
    chk("abort_word7", mem[7], ref_mem[7]);
    chk("abort_idle", {31'b0, busy}, 0);
    chk("abort_no_ack", {31'b0, ack0 | ack1}, 0);

    // Address change during ACCESS is ignored
    issue(1, 1, 16'd9, 32'h99999999);
    model_access(1, 1, 16'd9, 32'h99999999);
    run_idle(20);
    we_cnt = 0;
    issue(0, 0, 16'd2, 32'h0);
    model_access(0, 0, 16'd2, 32'h0);
    step();
    addr0 = 16'd9;
    run_idle(20);
    chk("hold_we_cycles", we_cnt, 0);
    chk("hold_rd0", rd0, ref_mem[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single-port 32x32 data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Arbitrates with round-robin priority and sequences each access through a 3-state FSM.
- Drives the memory's address, write-data and write-enable, and returns registered read data with a one-cycle ack pulse.
- Sits between the requesters and the data memory; it is the only driver of the memory ports.

Parameters:
- AW, 16, address width of requester and memory ports
- DW, 32, data width
- DEPTH, 32, number of valid memory words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 access request
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  AW  requester 0 word address
- wd0  in  DW  requester 0 write data
- ack0  out  1  requester 0 completion pulse
- rd0  out  DW  requester 0 read data (registered)
- err0  out  1  requester 0 out-of-range flag, valid with ack0
- req1, we1, addr1, wd1, ack1, rd1, err1: same as port 0, for requester 1
- dm_addr  out  AW  memory address
- dm_wd  out  DW  memory write data
- dm_we  out  1  memory write enable
- dm_rd  in  DW  memory combinational read data
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; last_grant=1 (port 0 wins the first tie); latched addr/wd/we/owner=0.
- Reset values: ack0=ack1=0, err0=err1=0, rd0=rd1=0, dm_we=0, dm_addr=0, dm_wd=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. No other transitions.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch addr, wd, we and owner; set oor = (addr >= DEPTH); go to ACCESS.
- ACCESS (exactly 1 cycle):
  - dm_addr and dm_wd come from the latches.
  - dm_we = latched_we & ~oor. Out-of-range writes are dropped.
  - At the rising edge: rd_owner <= (oor ? 0 : dm_rd) for reads; rd_owner is unchanged for writes.
  - At the same edge: err_owner <= oor; ack_owner <= 1; last_grant <= owner; go to RESP.
- RESP (1 cycle):
  - ack_owner=1, err valid; dm_we=0; no arbitration in this cycle.
  - Then go to IDLE; ack and err clear to 0.
- Outside ACCESS: dm_we=0; dm_addr and dm_wd hold their last latched values.
- Latency: request sampled in IDLE; ack 2 cycles later. Peak throughput is 1 access per 3 cycles.
- Handshake:
  - Requester holds req/we/addr/wd stable until it sees ack.
  - Requester may drop req, or present a new request, on the edge that ends RESP.
  - Signals are only sampled in IDLE, so mid-access changes are ignored.
- Fairness:
  - With both ports continuously requesting, grants alternate 0,1,0,1…
  - A single requester may be granted back-to-back.
- Reset mid-access: state returns to IDLE immediately and dm_we drops asynchronously, so no write occurs at the next edge. No ack is issued for the aborted request.
- rd0/rd1: hold the last read value until overwritten by a new read to the same port; writes do not modify them.
- Address width: dm_addr carries the full AW bits; the out-of-range check is what protects the memory.

Decomposition:
- Shared package dm_pkg:
  - State encoding constants: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port-index constants P0=1'b0, P1=1'b1.
  - DEPTH default.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker (inputs req0, req1, last_grant; outputs gnt_valid, gnt_idx). The FSM and datapath latches stay in dm_arbiter.

Test Plan:
- Single write then read, port 0: write addr0=5, wd0=0xDEADBEEF → dm_we high exactly 1 cycle with dm_addr=5; ack0 2 cycles after request. Then read addr0=5 → rd0=0xDEADBEEF, err0=0.
- Simultaneous requests from reset: port 0 reads addr 3, port 1 writes 0x12345678 to addr 3 → port 0 granted first (rd0=0x00000000), then port 1. A repeat read by port 0 returns 0x12345678.
- Continuous contention: req0=req1=1 for 12 cycles → 4 grants in order 0,1,0,1. Acks never overlap; busy=1 except in IDLE cycles.
- Out of range: port 1 writes addr1=32, wd1=0xFFFFFFFF → dm_we stays 0, ack1 and err1 both high for 1 cycle. Reading addr1=40 → rd1=0, err1=1.
- Reset mid-access: assert reset during ACCESS of a write to addr 7 → dm_we falls immediately, no ack; memory word 7 keeps its old value; state=IDLE after reset release.
- Stable-hold check: change addr0 from 2 to 9 during ACCESS → memory accessed at 2 only; rd0 reflects word 2.
